// File: rtl/spgd_pkg.sv
// rtl/spgd_pkg.sv - shared state encoding and DAC range constants for the SPGD dither stepper
package spgd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLUS   = 2'd1,
        ST_MINUS  = 2'd2,
        ST_UPDATE = 2'd3
    } spgd_state_e;

    localparam int DAC_WIDTH_DEF = 14;

    function automatic longint dac_max_for(input int width);
        return (longint'(1) << width) - 1;
    endfunction

    function automatic longint u_reset_for(input int width);
        return longint'(1) << (width - 1);
    endfunction

    localparam longint DAC_MAX = dac_max_for(DAC_WIDTH_DEF);
    localparam longint U_RESET = u_reset_for(DAC_WIDTH_DEF);

endpackage

// File: rtl/dac_sat_add.sv
// rtl/dac_sat_add.sv - signed offset added onto an unsigned DAC code, clamped to [0, MAX_CODE]
module dac_sat_add
    import spgd_pkg::*;
#(
    parameter int     DAC_WIDTH = DAC_WIDTH_DEF,
    parameter int     OFF_WIDTH = 33,
    parameter longint MAX_CODE  = DAC_MAX
) (
    input  logic [DAC_WIDTH-1:0]        base,
    input  logic signed [OFF_WIDTH-1:0] offset,
    output logic [DAC_WIDTH-1:0]        sum
);

    // Two guard bits so neither overflow direction can wrap before the clamp.
    localparam int SW = ((OFF_WIDTH > DAC_WIDTH) ? OFF_WIDTH : DAC_WIDTH) + 2;
    localparam logic signed [SW-1:0] MAX_W = SW'(MAX_CODE);

    logic signed [SW-1:0] wide;

    assign wide = $signed({{(SW-DAC_WIDTH){1'b0}}, base}) + SW'(offset);

    always_comb begin
        if (wide[SW-1]) begin
            sum = '0;
        end else if (wide > MAX_W) begin
            sum = DAC_WIDTH'(MAX_W);
        end else begin
            sum = wide[DAC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/spgd_dither_step.sv
// rtl/spgd_dither_step.sv - SPGD dither/measure/update sequencer driving a DAC control code
module spgd_dither_step
    import spgd_pkg::*;
#(
    parameter int FLOAT_WIDTH = 32,
    parameter int DAC_WIDTH   = DAC_WIDTH_DEF
) (
    input  logic                          ADC_CLK,
    input  logic                          RST_N,
    input  logic                          enable,
    input  logic signed [FLOAT_WIDTH-1:0] METRIC_IN,
    input  logic                          METRIC_VALID,
    input  logic [DAC_WIDTH-1:0]          DITHER_AMP,
    input  logic signed [FLOAT_WIDTH-1:0] STEP_GAIN,
    output logic [DAC_WIDTH-1:0]          DAC_CODE_OUT,
    output logic [DAC_WIDTH-1:0]          U_OUT,
    output logic                          ITER_DONE,
    output logic                          BUSY,
    output logic [1:0]                    STATE_OUT
);

    localparam int DW = FLOAT_WIDTH + 1;
    localparam int PW = 2 * FLOAT_WIDTH + 1;
    localparam logic [DAC_WIDTH-1:0] U_INIT =
        DAC_WIDTH'((DAC_WIDTH == DAC_WIDTH_DEF) ? U_RESET : u_reset_for(DAC_WIDTH));

    spgd_state_e state, state_next;

    logic [DAC_WIDTH-1:0]          u, u_base;
    logic [DAC_WIDTH-1:0]          dac, dac_next;
    logic signed [FLOAT_WIDTH-1:0] jp, jp_next, jm, jm_next;
    logic                          stale, stale_next;
    logic                          iter_done;

    logic signed [DW-1:0] diff;
    logic signed [PW-1:0] product;
    logic signed [DW-1:0] step;
    logic signed [DW-1:0] amp_pos, amp_neg;
    logic [DAC_WIDTH-1:0] upd_sum, plus_code, minus_code;

    // Q16.16 x Q16.16 leaves 2*16 fraction bits; the arithmetic shift floors toward -inf.
    assign diff    = DW'(jp) - DW'(jm);
    assign product = PW'(diff) * PW'(STEP_GAIN);
    assign step    = DW'(product >>> FLOAT_WIDTH);
    assign amp_pos = DW'({1'b0, DITHER_AMP});
    assign amp_neg = -amp_pos;

    // Dither codes are formed from the u that will be current when they are driven.
    assign u_base = (state == ST_UPDATE) ? upd_sum : u;

    dac_sat_add #(.DAC_WIDTH(DAC_WIDTH), .OFF_WIDTH(DW), .MAX_CODE(dac_max_for(DAC_WIDTH)))
        u_upd_add (.base(u), .offset(step), .sum(upd_sum));

    dac_sat_add #(.DAC_WIDTH(DAC_WIDTH), .OFF_WIDTH(DW), .MAX_CODE(dac_max_for(DAC_WIDTH)))
        u_plus_add (.base(u_base), .offset(amp_pos), .sum(plus_code));

    dac_sat_add #(.DAC_WIDTH(DAC_WIDTH), .OFF_WIDTH(DW), .MAX_CODE(dac_max_for(DAC_WIDTH)))
        u_minus_add (.base(u_base), .offset(amp_neg), .sum(minus_code));

    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        jp_next    = jp;
        jm_next    = jm;
        stale_next = stale;
        dac_next   = u_base;
        case (state)
            ST_IDLE: begin
                if (enable) state_next = ST_PLUS;
            end
            ST_PLUS, ST_MINUS: begin
                // Abort takes priority over any metric arriving in the same cycle.
                if (!enable) begin
                    state_next = ST_IDLE;
                    jp_next    = '0;
                    jm_next    = '0;
                end else if (METRIC_VALID) begin
                    if (!stale) begin
                        stale_next = 1'b1;
                    end else if (state == ST_PLUS) begin
                        jp_next    = METRIC_IN;
                        state_next = ST_MINUS;
                    end else begin
                        jm_next    = METRIC_IN;
                        state_next = ST_UPDATE;
                    end
                end
            end
            ST_UPDATE: begin
                state_next = enable ? ST_PLUS : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (state_next != state) stale_next = 1'b0;
        case (state_next)
            ST_PLUS:  dac_next = plus_code;
            ST_MINUS: dac_next = minus_code;
            default:  dac_next = u_base;
        endcase
    end

    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            u         <= U_INIT;
            dac       <= U_INIT;
            jp        <= '0;
            jm        <= '0;
            stale     <= 1'b0;
            iter_done <= 1'b0;
        end else begin
            u         <= u_base;
            dac       <= dac_next;
            jp        <= jp_next;
            jm        <= jm_next;
            stale     <= stale_next;
            iter_done <= (state == ST_UPDATE);
        end
    end

    assign DAC_CODE_OUT = dac;
    assign U_OUT        = u;
    assign ITER_DONE    = iter_done;
    assign BUSY         = (state != ST_IDLE);
    assign STATE_OUT    = state;

endmodule

// File: tb/tb_spgd_dither_step.sv
// tb/tb_spgd_dither_step.sv - self-checking bench for spgd_dither_step
module tb_spgd_dither_step;

    logic        ADC_CLK = 1'b0;
    logic        RST_N;
    logic        enable;
    logic [31:0] METRIC_IN;
    logic        METRIC_VALID;
    logic [13:0] DITHER_AMP;
    logic [31:0] STEP_GAIN;
    logic [13:0] DAC_CODE_OUT;
    logic [13:0] U_OUT;
    logic        ITER_DONE;
    logic        BUSY;
    logic [1:0]  STATE_OUT;

    int checks   = 0;
    int failures = 0;
    int model_u  = 8192;

    spgd_dither_step dut (
        .ADC_CLK      (ADC_CLK),
        .RST_N        (RST_N),
        .enable       (enable),
        .METRIC_IN    (METRIC_IN),
        .METRIC_VALID (METRIC_VALID),
        .DITHER_AMP   (DITHER_AMP),
        .STEP_GAIN    (STEP_GAIN),
        .DAC_CODE_OUT (DAC_CODE_OUT),
        .U_OUT        (U_OUT),
        .ITER_DONE    (ITER_DONE),
        .BUSY         (BUSY),
        .STATE_OUT    (STATE_OUT)
    );

    always #5 ADC_CLK = ~ADC_CLK;

    task automatic tick();
        @(posedge ADC_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_plus(input int u, input int amp);
        return (u + amp > 16383) ? 16383 : u + amp;
    endfunction

    function automatic int sat_minus(input int u, input int amp);
        return (u - amp < 0) ? 0 : u - amp;
    endfunction

    // u + floor((Jp - Jm) * gain / 2^32), clamped to the 14-bit code range.
    function automatic int model_next_u(input int u, input logic [31:0] jp,
                                        input logic [31:0] jm, input logic [31:0] gain);
        logic signed [127:0] d, p, r, uu;
        d  = $signed({{96{jp[31]}}, jp}) - $signed({{96{jm[31]}}, jm});
        p  = d * $signed({{96{gain[31]}}, gain});
        p  = p >>> 32;
        uu = 128'(u);
        r  = p + uu;
        if (r < 0) return 0;
        if (r > 16383) return 16383;
        return int'(r);
    endfunction

    task automatic pulse(input logic [31:0] value, input int gap);
        for (int g = 0; g < gap; g++) tick();
        METRIC_VALID = 1'b1;
        METRIC_IN    = value;
        tick();
        METRIC_VALID = 1'b0;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        RST_N  = 1'b0;
        #2;
        RST_N  = 1'b1;
        tick();
        model_u = 8192;
    endtask

    task automatic iterate(input logic [31:0] jp, input logic [31:0] jm, input logic [31:0] sp,
                           input int amp, input logic [31:0] gain, input bit stay, input int gap);
        int exp_u;
        DITHER_AMP   = amp[13:0];
        STEP_GAIN    = gain;
        enable       = 1'b1;
        METRIC_VALID = 1'($urandom_range(0, 1));
        METRIC_IN    = $urandom;
        tick();
        METRIC_VALID = 1'b0;
        check("plus_state", STATE_OUT, 1);
        check("plus_dac", DAC_CODE_OUT, sat_plus(model_u, amp));
        pulse(sp, gap);
        pulse(jp, gap);
        check("minus_state", STATE_OUT, 2);
        check("minus_dac", DAC_CODE_OUT, sat_minus(model_u, amp));
        pulse($urandom, gap);
        pulse(jm, gap);
        check("update_state", STATE_OUT, 3);
        check("update_busy", BUSY, 1);
        check("update_dac", DAC_CODE_OUT, model_u);
        exp_u = model_next_u(model_u, jp, jm, gain);
        if (!stay) enable = 1'b0;
        METRIC_VALID = 1'b1;
        METRIC_IN    = $urandom;
        tick();
        METRIC_VALID = 1'b0;
        check("iter_done", ITER_DONE, 1);
        check("iter_u", U_OUT, exp_u);
        if (stay) begin
            check("restart_state", STATE_OUT, 1);
            check("restart_dac", DAC_CODE_OUT, sat_plus(exp_u, amp));
            enable = 1'b0;
            tick();
            check("abort_plus_state", STATE_OUT, 0);
        end else begin
            check("idle_state", STATE_OUT, 0);
        end
        check("idle_dac", DAC_CODE_OUT, exp_u);
        if (!stay) tick();
        check("iter_done_single", ITER_DONE, 0);
        check("idle_u", U_OUT, exp_u);
        model_u = exp_u;
    endtask

    initial begin
        RST_N = 1'b0; enable = 1'b0; METRIC_VALID = 1'b0; METRIC_IN = '0;
        DITHER_AMP = '0; STEP_GAIN = '0;
        repeat (2) @(posedge ADC_CLK);
        #1;
        check("rst_state", STATE_OUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_dac", DAC_CODE_OUT, 8192);
        check("rst_u", U_OUT, 8192);
        check("rst_iter", ITER_DONE, 0);
        RST_N = 1'b1;
        tick();
        check("idle_hold", STATE_OUT, 0);

        iterate(32'h0001_8000, 32'h0001_0000, $urandom, 100, 32'h00C8_0000, 0, 0);
        check("basic_up_u", U_OUT, 8292);

        do_reset();
        iterate(32'h0001_0000, 32'h0001_8000, $urandom, 100, 32'h00C8_0000, 0, 1);
        check("basic_down_u", U_OUT, 8092);
        iterate(32'h0000_0000, 32'h0000_0001, $urandom, 100, 32'h0001_0000, 0, 0);
        check("floor_step_u", U_OUT, 8091);

        do_reset();
        iterate(32'h0001_0000, 32'h0000_0000, $urandom, 0, 32'h1FDE_0000, 0, 0);
        check("climb_u", U_OUT, 16350);
        iterate(32'h0001_0000, 32'h0000_0000, $urandom, 100, 32'h7FFF_0000, 0, 0);
        check("clamp_high_u", U_OUT, 16383);
        do_reset();
        iterate(32'h0000_0000, 32'h0001_0000, $urandom, 0, 32'h1FCE_0000, 0, 0);
        check("descend_u", U_OUT, 50);
        iterate(32'h0001_0000, 32'h0001_0000, $urandom, 100, 32'h0001_0000, 0, 2);
        check("minus_floor_u", U_OUT, 50);

        iterate(32'h0002_0000, 32'h0001_0000, 32'h1111_0000, 100, 32'h0001_0000, 0, 0);
        check("stale_discard_u", U_OUT, 51);

        iterate(32'h0003_0000, 32'h0001_0000, $urandom, 40, 32'h0010_0000, 1, 1);

        enable = 1'b1; DITHER_AMP = 14'd77;
        tick();
        check("abort_plus_entry", STATE_OUT, 1);
        pulse($urandom, 0);
        pulse($urandom, 0);
        check("abort_minus_entry", STATE_OUT, 2);
        pulse($urandom, 0);
        METRIC_VALID = 1'b1; METRIC_IN = $urandom; enable = 1'b0;
        tick();
        METRIC_VALID = 1'b0;
        check("abort_state", STATE_OUT, 0);
        check("abort_u", U_OUT, model_u);
        check("abort_dac", DAC_CODE_OUT, model_u);
        check("abort_iter", ITER_DONE, 0);
        tick();
        check("abort_iter_later", ITER_DONE, 0);

        enable = 1'b1; DITHER_AMP = 14'd300;
        tick();
        check("rstmid_plus", STATE_OUT, 1);
        check("rstmid_plus_dac", DAC_CODE_OUT, sat_plus(model_u, 300));
        RST_N = 1'b0; enable = 1'b0;
        #1;
        check("rstmid_state", STATE_OUT, 0);
        check("rstmid_busy", BUSY, 0);
        check("rstmid_dac", DAC_CODE_OUT, 8192);
        check("rstmid_u", U_OUT, 8192);
        check("rstmid_iter", ITER_DONE, 0);
        #2;
        RST_N = 1'b1;
        tick();
        check("rstmid_release", STATE_OUT, 0);
        model_u = 8192;

        for (int i = 0; i < 24; i++) begin
            int t1, t2, t3, amp;
            logic [31:0] jp, jm, gain;
            t1 = int'($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000;
            t2 = int'($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000;
            t3 = int'($urandom_range(0, 32'h0020_0000)) - 32'sh0010_0000;
            jp = t1; jm = t2; gain = t3;
            if (i % 6 == 5) begin
                jp = $urandom; jm = $urandom; gain = $urandom;
            end
            amp = (i % 5 == 0) ? 0 : int'($urandom_range(0, 2000));
            iterate(jp, jm, $urandom, amp, gain, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spgd_dither_step.md
SPGD_DITHER_STEP -- requirements
Module: spgd_dither_step

Interface
REQ-001 Parameter FLOAT_WIDTH, default 32: width of signed Q16.16 metric and gain words.
REQ-002 Parameter DAC_WIDTH, default 14: width of unsigned DAC codes.
REQ-003 ADC_CLK  input  1: sole clock; all state changes on its rising edge.
REQ-004 RST_N  input  1: reset, asynchronous, active-low.
REQ-005 enable  input  1: high = run SPGD iterations; low = hold in IDLE.
REQ-006 METRIC_IN  input  FLOAT_WIDTH: signed Q16.16 calibrated metric (volts), from the calibration register stage.
REQ-007 METRIC_VALID  input  1: one-cycle pulse marking a new METRIC_IN value.
REQ-008 DITHER_AMP  input  DAC_WIDTH: unsigned perturbation amplitude in DAC codes.
REQ-009 STEP_GAIN  input  FLOAT_WIDTH: signed Q16.16 gain in codes per volt.
REQ-010 DAC_CODE_OUT  output  DAC_WIDTH: registered code driven to the DAC.
REQ-011 U_OUT  output  DAC_WIDTH: registered current control estimate u.
REQ-012 ITER_DONE  output  1: one-cycle pulse when u is updated.
REQ-013 BUSY  output  1: high in any state other than IDLE.
REQ-014 STATE_OUT  output  2: current state encoding (IDLE=0, PLUS=1, MINUS=2, UPDATE=3).

Function
REQ-015 The block SHALL implement four states: IDLE, PLUS, MINUS, UPDATE.
REQ-016 IDLE: DAC_CODE_OUT = u; enable high moves to PLUS next cycle.
REQ-017 PLUS: DAC_CODE_OUT = min(u + DITHER_AMP, 2^DAC_WIDTH-1), valid the cycle after entering PLUS.
REQ-018 MINUS: DAC_CODE_OUT = max(u - DITHER_AMP, 0), valid the cycle after entering MINUS.
REQ-019 In PLUS and MINUS the first METRIC_VALID pulse SHALL be discarded as stale; the second SHALL be captured (Jp in PLUS, Jm in MINUS) and the state SHALL advance next cycle.
REQ-020 A METRIC_VALID pulse on the cycle of state entry SHALL count as the stale (first) pulse.
REQ-021 UPDATE lasts exactly one cycle: diff = Jp - Jm at FLOAT_WIDTH+1 bits; product = diff * STEP_GAIN (Q32.32, full width); step = product arithmetically shifted right 32 (floor); u <= clamp(u + step, 0, 2^DAC_WIDTH-1).
REQ-022 ITER_DONE SHALL pulse high for the cycle following UPDATE, coincident with the new U_OUT.
REQ-023 After UPDATE: enable high -> PLUS; enable low -> IDLE.
REQ-024 METRIC_VALID in IDLE or UPDATE SHALL be ignored.
REQ-025 enable low in PLUS or MINUS SHALL abort to IDLE next cycle, u unchanged, captured metrics discarded; abort wins over a simultaneous METRIC_VALID.
REQ-026 DITHER_AMP and STEP_GAIN SHALL be sampled every cycle (no shadowing); changes apply from the next cycle.
REQ-027 DITHER_AMP = 0 SHALL still run the full sequence (Jp, Jm both measured at u).

Reset
REQ-028 On RST_N low: state = IDLE, u = 2^(DAC_WIDTH-1) (8192), DAC_CODE_OUT = 8192, U_OUT = 8192, Jp = Jm = 0, stale flag cleared, ITER_DONE = 0, BUSY = 0, STATE_OUT = 0.
REQ-029 Reset asserted mid-iteration SHALL take effect immediately; first state after release is IDLE.

Structure
REQ-030 A shared package spgd_pkg SHALL hold the state enumeration, DAC_MAX = 2^DAC_WIDTH-1 and U_RESET = 2^(DAC_WIDTH-1).
REQ-031 One sub-module, dac_sat_add, SHALL perform signed-offset addition onto an unsigned DAC code with clamping to [0, DAC_MAX]; used for PLUS, MINUS and UPDATE.

Verification
REQ-032 u=8192, AMP=100, Jp=0x0001_8000 (1.5 V), Jm=0x0001_0000 (1.0 V), GAIN=0x00C8_0000 (200.0) -> DAC 8292 then 8092, U_OUT=8292, ITER_DONE one pulse.
REQ-033 Same but Jp=1.0 V, Jm=1.5 V -> U_OUT=8092; diff=0xFFFF_FFFF, GAIN=0x0001_0000 -> step=-1 (floor), U_OUT decrements by 1.
REQ-034 u=16350, AMP=100 -> PLUS drives 16383; large positive step -> U_OUT=16383; u=50, AMP=100 -> MINUS drives 0.
REQ-035 Two METRIC_VALID pulses in PLUS with values 0x1111_0000 then 0x0002_0000 -> Jp=0x0002_0000; pulse in UPDATE has no effect.
REQ-036 enable dropped in MINUS together with METRIC_VALID -> IDLE next cycle, U_OUT unchanged, DAC_CODE_OUT=u, no ITER_DONE.
REQ-037 RST_N pulsed low in PLUS -> all outputs to reset values asynchronously, STATE_OUT=0 after release.
